// File: rtl/axi4_default_slave.sv
// AXI4 default slave: completes transactions to unmapped addresses with DECERR.
// Optional build macro AXI4_DEFSLV_ERR_CNT_EN adds saturating write/read error counters.
module axi4_default_slave #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [7:0]            s_awlen,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic [USER_WIDTH-1:0] s_buser,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [7:0]            s_arlen,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic [USER_WIDTH-1:0] s_ruser,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  wlast_err
`ifdef AXI4_DEFSLV_ERR_CNT_EN
  ,
  output logic [15:0]           err_wr_cnt,
  output logic [15:0]           err_rd_cnt
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  wstate_t             wstate_q, wstate_d;
  logic [ID_WIDTH-1:0] awid_q, awid_d;
  logic [CNT_W-1:0]    awlen_q, awlen_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic                werr_q, werr_d;

  rstate_t             rstate_q, rstate_d;
  logic [ID_WIDTH-1:0] arid_q, arid_d;
  logic [CNT_W-1:0]    arlen_q, arlen_d;
  logic [CNT_W-1:0]    rcnt_q, rcnt_d;

  // Holds address ready low for the cycle in which reset is still being released.
  logic                rst_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q <= W_IDLE;
      awid_q   <= '0;
      awlen_q  <= '0;
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
      rstate_q <= R_IDLE;
      arid_q   <= '0;
      arlen_q  <= '0;
      rcnt_q   <= '0;
      rst_q    <= 1'b1;
    end else begin
      wstate_q <= wstate_d;
      awid_q   <= awid_d;
      awlen_q  <= awlen_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
      rstate_q <= rstate_d;
      arid_q   <= arid_d;
      arlen_q  <= arlen_d;
      rcnt_q   <= rcnt_d;
      rst_q    <= 1'b0;
    end
  end

  // Write channel: accept address, sink beats until WLAST, return one B.
  always_comb begin
    wstate_d = wstate_q;
    awid_d   = awid_q;
    awlen_d  = awlen_q;
    wcnt_d   = wcnt_q;
    werr_d   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (s_awvalid && s_awready) begin
          awid_d   = s_awid;
          awlen_d  = s_awlen;
          wcnt_d   = '0;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_wvalid) begin
          if (wcnt_q != CNT_MAX) wcnt_d = wcnt_q + CNT_W'(1);
          if (s_wlast) begin
            werr_d   = (wcnt_q != awlen_q);
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read channel: accept address, return arlen+1 zero beats.
  always_comb begin
    rstate_d = rstate_q;
    arid_d   = arid_q;
    arlen_d  = arlen_q;
    rcnt_d   = rcnt_q;
    case (rstate_q)
      R_IDLE: begin
        if (s_arvalid && s_arready) begin
          arid_d   = s_arid;
          arlen_d  = s_arlen;
          rcnt_d   = '0;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_rready) begin
          if (rcnt_q == arlen_q) rstate_d = R_IDLE;
          else                   rcnt_d   = rcnt_q + CNT_W'(1);
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign s_awready = (wstate_q == W_IDLE) && !rst_q;
  assign s_wready  = (wstate_q == W_DATA);
  assign s_bvalid  = (wstate_q == W_RESP);
  assign s_bid     = s_bvalid ? awid_q : '0;
  assign s_bresp   = s_bvalid ? RESP_DECERR : 2'b00;
  assign s_buser   = '0;
  assign wlast_err = werr_q;

  assign s_arready = (rstate_q == R_IDLE) && !rst_q;
  assign s_rvalid  = (rstate_q == R_DATA);
  assign s_rid     = s_rvalid ? arid_q : '0;
  assign s_rresp   = s_rvalid ? RESP_DECERR : 2'b00;
  assign s_rlast   = s_rvalid && (rcnt_q == arlen_q);
  assign s_rdata   = '0;
  assign s_ruser   = '0;

`ifdef AXI4_DEFSLV_ERR_CNT_EN
  localparam int unsigned ERR_CNT_W = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  logic [ERR_CNT_W-1:0] err_wr_q, err_rd_q;

  // Completed-transaction counters, saturating.
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_wr_q <= '0;
      err_rd_q <= '0;
    end else begin
      if (s_bvalid && s_bready && (err_wr_q != ERR_MAX))
        err_wr_q <= err_wr_q + ERR_CNT_W'(1);
      if (s_rvalid && s_rready && s_rlast && (err_rd_q != ERR_MAX))
        err_rd_q <= err_rd_q + ERR_CNT_W'(1);
    end
  end

  assign err_wr_cnt = err_wr_q;
  assign err_rd_cnt = err_rd_q;
`endif

endmodule

// File: doc/axi4_default_slave.md
Name: axi4_default_slave

Overview:
- Downstream terminating endpoint for the AXI4 router.
- The router steers any transaction whose address decodes to no real slave into this block.
- The block completes such transactions protocol-correctly with DECERR responses: it sinks write bursts and generates full-length read bursts, so masters never hang on unmapped addresses.
- Write and read channels run as two independent state machines.

Parameters:
- DATA_WIDTH, 64, RDATA width
- ID_WIDTH, 4, AXI ID width
- USER_WIDTH, 1, BUSER/RUSER width (driven 0)

Ports:
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- s_awid  in  ID_WIDTH  write address ID
- s_awlen  in  8  write burst length minus 1
- s_awvalid  in  1  AW valid
- s_awready  out  1  AW ready
- s_wlast  in  1  last write beat
- s_wvalid  in  1  W valid
- s_wready  out  1  W ready
- s_bid  out  ID_WIDTH  response ID
- s_bresp  out  2  write response
- s_buser  out  USER_WIDTH  0
- s_bvalid  out  1  B valid
- s_bready  in  1  B ready
- s_arid  in  ID_WIDTH  read address ID
- s_arlen  in  8  read burst length minus 1
- s_arvalid  in  1  AR valid
- s_arready  out  1  AR ready
- s_rid  out  ID_WIDTH  read ID
- s_rdata  out  DATA_WIDTH  read data, always 0
- s_rresp  out  2  read response
- s_ruser  out  USER_WIDTH  0
- s_rlast  out  1  last read beat
- s_rvalid  out  1  R valid
- s_rready  in  1  R ready
- wlast_err  out  1  one-cycle pulse on WLAST/AWLEN mismatch

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- While areset=1, all outputs are 0 and both FSMs go to IDLE.
- All outputs are decoded from registered state only. There are no combinational input-to-output paths.
- s_bresp and s_rresp are constant 2'b11 (DECERR) whenever the matching valid is high.
- Write FSM, IDLE → W_DATA → W_RESP:
  - IDLE: s_awready=1. On s_awvalid, capture awid/awlen, clear beat counter wcnt (8 bits), go to W_DATA.
  - W_DATA: s_wready=1. Each s_wvalid increments wcnt.
  - On s_wvalid & s_wlast, go to W_RESP. wlast_err pulses the next cycle if wcnt != awlen at that beat.
  - If wcnt reaches awlen without WLAST, keep accepting beats until WLAST, and pulse wlast_err when WLAST arrives. wcnt saturates at 255.
  - W_RESP: s_bvalid=1, s_bid=captured ID, held stable until s_bready, then go to IDLE.
  - Latency: AW handshake at cycle N gives s_wready=1 at N+1. WLAST handshake at cycle M gives s_bvalid=1 at M+1.
  - W beats presented before AW is accepted are not taken (s_wready=0 in IDLE). This is legal slave behaviour.
- Read FSM, IDLE → R_DATA:
  - IDLE: s_arready=1. On s_arvalid, capture arid/arlen, clear rcnt, go to R_DATA.
  - R_DATA: s_rvalid=1, s_rid=captured ID, s_rdata=0, s_rlast=(rcnt==arlen).
  - Each s_rready while valid increments rcnt. The handshake on the last beat returns to IDLE.
  - Latency: AR handshake at N gives the first beat at N+1. An arlen=L burst with s_rready held high completes in L+1 cycles.
  - Outputs stay stable under backpressure.
- Only one outstanding transaction per channel. AW/AR ready is low until the current transaction completes, and is high again the cycle after the final B/R handshake.
- Read and write FSMs are fully independent. Simultaneous AW and AR are both accepted in the same cycle.
- arlen=0 gives a single beat with s_rlast=1. arlen=255 gives 256 beats, and the counter must not wrap early.
- areset mid-burst abandons the burst immediately. There is no pending response after reset.

Optional Feature:
- Macro: AXI4_DEFSLV_ERR_CNT_EN
- When defined, adds two outputs, err_wr_cnt[15:0] and err_rd_cnt[15:0].
  - Each increments by 1 on every B handshake (write) or final R handshake (read).
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, neither port nor counter exists, and the module is otherwise identical.

Test Plan:
- Write, no stall:
  - Stimulus: AW id=4'h5, awlen=3; 4 W beats with wlast on the 4th; bready=1.
  - Required: s_bvalid one cycle after WLAST, bid=5, bresp=2'b11, wlast_err=0.
- Read with backpressure:
  - Stimulus: AR id=4'hA, arlen=7; rready toggled 1,0,1,0…
  - Required: exactly 8 beats, rid=A, rresp=2'b11, rdata=0, rlast only on the 8th; valid and data held during stalls.
- Early WLAST:
  - Stimulus: awlen=3, wlast on the 2nd beat.
  - Required: wlast_err pulses once; B is still returned with DECERR; FSM back to IDLE.
- Concurrent channels:
  - Stimulus: AW (id=1, awlen=0) and AR (id=2, arlen=255) in the same cycle.
  - Required: both accepted; B id=1 and 256 R beats id=2 complete independently; awready stays 0 until B completes.
- Reset mid-burst:
  - Stimulus: assert areset after the 3rd R beat of arlen=15.
  - Required: next cycle rvalid=0, arready=0; after deassert arready=1 and no stray beats.
- Feature build with AXI4_DEFSLV_ERR_CNT_EN:
  - Stimulus: 3 writes and 2 reads.
  - Required: err_wr_cnt=3, err_rd_cnt=2.
